// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem fetches and
// buffers returned words for IF/ID. Define FETCH_PERF_EN to add fetch/bubble counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] instruction_read,
    output logic [31:0] instruction_addr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    // state   | meaning
    // S_FETCH | request issued at pc (imem_req high)
    // S_WAIT  | one request outstanding, awaiting rvalid
    // S_FULL  | buffer full, fetching paused until IF/ID pops

    localparam int            PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_FULL} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   req_addr;
    logic [31:0]   last_addr;
    logic          drop;
    logic [31:0]   buf_data [BUF_DEPTH];
    logic [31:0]   buf_addr [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          accept;
    logic          push;
    logic          pop;
    logic          has_space;

    assign accept     = imem_req & imem_gnt;
    assign push       = (state == S_WAIT) & imem_rvalid & ~drop & ~branch_taken;
    assign pop        = fetch_valid & ~id_stall & ~branch_taken;
    assign count_next = count + CW'(push) - CW'(pop);
    assign has_space  = (count_next != DEPTH_C);

    assign imem_addr        = pc;
    assign fetch_valid      = (count != '0);
    assign instruction_read = fetch_valid ? buf_data[rd_ptr] : NOP;
    assign instruction_addr = fetch_valid ? buf_addr[rd_ptr] : last_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            imem_req <= 1'b0;
            pc       <= RESET_PC;
            req_addr <= '0;
            drop     <= 1'b0;
        end else if (branch_taken) begin
            pc <= {branch_target[31:2], 2'b00};
            // A response is still owed for the abandoned request; swallow it before refetching.
            if (accept || (state == S_WAIT && !imem_rvalid)) begin
                drop     <= 1'b1;
                state    <= S_WAIT;
                imem_req <= 1'b0;
            end else begin
                drop     <= 1'b0;
                state    <= S_FETCH;
                imem_req <= 1'b1;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        pc       <= pc + 32'd4;
                        req_addr <= pc;
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop <= 1'b0;
                        if (has_space) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state    <= S_FULL;
                            imem_req <= 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_addr <= '0;
        end else if (branch_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                last_addr <= buf_addr[rd_ptr];
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_rdata;
            buf_addr[wr_ptr] <= req_addr;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (push && fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (!id_stall && !fetch_valid && bubble_count != 32'hFFFF_FFFF) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: table vectors, directed redirect/reset sequences and a
// randomized run checked against a program-order model of the delivered stream.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] instruction_read;
    logic [31:0] instruction_addr;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_stall         (id_stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .fetch_valid      (fetch_valid),
        .instruction_read (instruction_read),
        .instruction_addr (instruction_addr)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count      (fetch_count),
        .bubble_count     (bubble_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // memory model: gnt_mode 0=random 1=always 2=never; mem_lat 0=random 1..4
    int          gnt_mode;
    int          mem_lat;
    bit          pend;
    int          mwait;
    logic [31:0] paddr;

    // samples taken mid-cycle, and the program-order reference
    logic        s_req, s_gnt, s_rv, s_fv;
    logic [31:0] s_addr, s_iaddr, s_inst;
    logic [31:0] exp_pc;
    bit          prev_hold, prev_br;
    logic [31:0] prev_addr;
    int          pops;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        fv;
        logic [31:0] iaddr;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_mem();
        case (gnt_mode)
            0:       imem_gnt = ($urandom_range(0, 1) == 1);
            1:       imem_gnt = 1'b1;
            default: imem_gnt = 1'b0;
        endcase
        if (pend && mwait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(paddr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) mwait--;
        end
    endtask

    // one clock: sample before the edge, update models, drive next inputs after it
    task automatic cycle();
        @(negedge clk);
        s_req   = imem_req;
        s_gnt   = imem_gnt;
        s_rv    = imem_rvalid;
        s_addr  = imem_addr;
        s_fv    = fetch_valid;
        s_iaddr = instruction_addr;
        s_inst  = instruction_read;
        if (prev_hold && !prev_br) begin
            chk("req_hold", 32'(s_req), 32'd1);
            chk("addr_hold", s_addr, prev_addr);
        end
        if (branch_taken) begin
            exp_pc = {branch_target[31:2], 2'b00};
        end else if (s_fv && !id_stall) begin
            chk("pop_addr", s_iaddr, exp_pc);
            chk("pop_data", s_inst, word_of(exp_pc));
            pops++;
            exp_pc = exp_pc + 32'd4;
        end
        prev_hold = s_req && !s_gnt;
        prev_addr = s_addr;
        prev_br   = branch_taken;
        @(posedge clk);
        #1;
        if (s_rv) pend = 1'b0;
        if (s_req && s_gnt) begin
            pend  = 1'b1;
            paddr = s_addr;
            mwait = (mem_lat == 0) ? int'($urandom_range(0, 3)) : mem_lat - 1;
        end
        drive_mem();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        branch_taken = 1'b0;
        pend         = 1'b0;
        imem_rvalid  = 1'b0;
        imem_gnt     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_instr", instruction_read, 32'h0000_0013);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_iaddr", instruction_addr, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_pc    = RST_PC;
        prev_hold = 1'b0;
        prev_br   = 1'b0;
        drive_mem();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit rv_seen;
        int got;
        int pops0;
        logic [31:0] wrap_exp [3];
        logic [31:0] wrap_got [3];

        tbl[0] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[1] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[2] = '{1'b0, 1'b0, 32'h04, 1'b0, 32'h00};
        tbl[3] = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
        tbl[4] = '{1'b0, 1'b0, 32'h08, 1'b0, 32'h00};
        tbl[5] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
        tbl[6] = '{1'b0, 1'b0, 32'h0C, 1'b0, 32'h04};
        tbl[7] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
        tbl[8] = '{1'b0, 1'b0, 32'h10, 1'b0, 32'h08};
        tbl[9] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        rst_n = 1'b0; id_stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        pend = 1'b0; mwait = 0; paddr = '0; pops = 0;
        prev_hold = 1'b0; prev_br = 1'b0; prev_addr = '0; exp_pc = RST_PC;

        // streaming with gnt tied high, one-cycle memory latency
        gnt_mode = 1; mem_lat = 1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            id_stall = tbl[k].stall;
            cycle();
            chk("tbl_req", 32'(s_req), 32'(tbl[k].req));
            chk("tbl_addr", s_addr, tbl[k].addr);
            chk("tbl_fv", 32'(s_fv), 32'(tbl[k].fv));
            chk("tbl_iaddr", s_iaddr, tbl[k].iaddr);
            chk("tbl_instr", s_inst, tbl[k].fv ? word_of(tbl[k].iaddr) : 32'h0000_0013);
        end

        // stall fills the buffer, release drains it on consecutive cycles
        id_stall = 1'b1;
        do_reset();
        repeat (6) cycle();
        chk("full_fv", 32'(s_fv), 32'd1);
        chk("full_req", 32'(s_req), 32'd0);
        chk("full_iaddr", s_iaddr, 32'h0);
        id_stall = 1'b0;
        cycle();
        chk("drain0_iaddr", s_iaddr, 32'h0);
        cycle();
        chk("drain1_fv", 32'(s_fv), 32'd1);
        chk("drain1_iaddr", s_iaddr, 32'h4);
        chk("refetch_req", 32'(s_req), 32'd1);
        chk("refetch_addr", s_addr, 32'h8);

        // redirect while waiting on address 8
        id_stall = 1'b0; mem_lat = 4;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (pend && paddr == 32'h8 && !imem_rvalid) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait8_reached", 32'(found), 32'd1);
        branch_taken = 1'b1; branch_target = 32'h0000_0103;
        cycle();
        branch_taken = 1'b0;
        rv_seen = 1'b0; found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_rv) rv_seen = 1'b1;
            if (s_req) begin
                found = 1'b1;
                break;
            end
        end
        chk("redir_req_seen", 32'(found), 32'd1);
        chk("redir_after_drop", 32'(rv_seen), 32'd1);
        chk("redir_addr", s_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_fv) begin
                found = 1'b1;
                break;
            end
        end
        chk("redir_fv_seen", 32'(found), 32'd1);
        chk("redir_first_addr", s_iaddr, 32'h100);

        // redirect coincident with pop and rvalid
        id_stall = 1'b1; mem_lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (pend && paddr == 32'h4 && imem_rvalid) begin
                found = 1'b1;
                break;
            end
        end
        chk("coinc_reached", 32'(found), 32'd1);
        id_stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0200;
        cycle();
        branch_taken = 1'b0; id_stall = 1'b1;
        cycle();
        chk("coinc_fv", 32'(s_fv), 32'd0);
        chk("coinc_req", 32'(s_req), 32'd1);
        chk("coinc_pc", s_addr, 32'h200);
        id_stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_fv) begin
                found = 1'b1;
                break;
            end
        end
        chk("coinc_fv_seen", 32'(found), 32'd1);
        chk("coinc_first_addr", s_iaddr, 32'h200);

        // pc wraps through the top of the address space
        id_stall = 1'b0; mem_lat = 1;
        do_reset();
        repeat (3) cycle();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFB;
        cycle();
        branch_taken = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && got < 3; i++) begin
            cycle();
            if (s_fv) begin
                wrap_got[got] = s_iaddr;
                got++;
            end
        end
        chk("wrap_count", 32'(got), 32'd3);
        for (int i = 0; i < 3; i++) chk("wrap_addr", (i < got) ? wrap_got[i] : 32'hXXXX_XXXX, wrap_exp[i]);

        // reset mid-wait followed by a stale response
        mem_lat = 8;
        do_reset();
        repeat (4) cycle();
        chk("stale_pending", 32'(pend), 32'd1);
        mem_lat = 1;
        do_reset();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        cycle();
        chk("stale_fv", 32'(s_fv), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_fv) begin
                found = 1'b1;
                break;
            end
        end
        chk("stale_fv_seen", 32'(found), 32'd1);
        chk("stale_first_addr", s_iaddr, RST_PC);
        chk("stale_first_data", s_inst, word_of(RST_PC));

`ifdef FETCH_PERF_EN
        // three accepted fetches and exactly two bubble cycles
        id_stall = 1'b1; gnt_mode = 1; mem_lat = 1;
        do_reset();
        repeat (8) cycle();
        id_stall = 1'b0;
        cycle();
        id_stall = 1'b1;
        repeat (8) cycle();
        gnt_mode = 2;
        id_stall = 1'b0;
        repeat (4) cycle();
        id_stall = 1'b1;
        cycle();
        chk("perf_fetch_count", fetch_count, 32'd3);
        chk("perf_bubble_count", bubble_count, 32'd2);
`endif

        // randomized traffic against the program-order model
        gnt_mode = 0; mem_lat = 0;
        id_stall = 1'b0;
        do_reset();
        pops0 = pops;
        for (int i = 0; i < 3000; i++) begin
            id_stall      = ($urandom_range(0, 99) < 30);
            branch_taken  = ($urandom_range(0, 99) < 4);
            branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : $urandom;
            cycle();
        end
        branch_taken = 1'b0;
        chk("random_progress", 32'((pops - pops0) >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
